// File: rtl/pipe_reg_ctrl_if.sv
// Control bundle between pipe_reg_ctrl and the PC / pipeline register instances.
// master = the sequencer side, slave = hazard unit, memory stage and pipeline registers.
interface pipe_reg_ctrl_if;
  logic        mem_req;
  logic        hazard;
  logic        branch_taken;
  logic        pc_ld;
  logic        ifid_ld;
  logic        ifid_clr;
  logic        idex_ld;
  logic        idex_clr;
  logic        exmem_ld;
  logic        memwb_ld;
  logic        mem_busy;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    input  mem_req, hazard, branch_taken,
    output pc_ld, ifid_ld, ifid_clr, idex_ld, idex_clr, exmem_ld, memwb_ld,
           mem_busy, stall_cnt, flush_cnt
  );

  modport slave (
    output mem_req, hazard, branch_taken,
    input  pc_ld, ifid_ld, ifid_clr, idex_ld, idex_clr, exmem_ld, memwb_ld,
           mem_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_reg_ctrl.sv
// Prioritised ld/clr sequencer for the PC and the four pipeline registers (reset > mem freeze > flush > bubble).
// Optional feature: define PIPE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipe_reg_ctrl #(
  parameter int WAIT_CYCLES = 3,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipe_reg_ctrl_if.master   bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_DONE} state_t;
  typedef enum logic [2:0] {W_RESET, W_FREEZE, W_FLUSH, W_BUBBLE, W_NORMAL} word_t;

  localparam bit             MEM_STALL_EN = (WAIT_CYCLES > 0);
  localparam bit             ONE_WAIT     = (WAIT_CYCLES == 1);
  localparam logic [CNT_W-1:0] LOAD_VAL   = (WAIT_CYCLES >= 2) ? CNT_W'(WAIT_CYCLES - 2) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  word_t            word;

  // Select which control word applies this cycle, highest priority first.
  always_comb begin
    word = W_NORMAL;
    if (rst)
      word = W_RESET;
    else if ((state == MEM_WAIT) || (state == RUN && bus.mem_req && MEM_STALL_EN))
      word = W_FREEZE;
    else if (bus.branch_taken)
      word = W_FLUSH;
    else if (bus.hazard)
      word = W_BUBBLE;
  end

  always_comb begin
    bus.pc_ld    = 1'b1;
    bus.ifid_ld  = 1'b1;
    bus.ifid_clr = 1'b0;
    bus.idex_ld  = 1'b1;
    bus.idex_clr = 1'b0;
    bus.exmem_ld = 1'b1;
    bus.memwb_ld = 1'b1;
    bus.mem_busy = 1'b0;
    case (word)
      W_RESET: begin
        bus.pc_ld    = 1'b0;
        bus.ifid_ld  = 1'b0;
        bus.ifid_clr = 1'b1;
        bus.idex_ld  = 1'b0;
        bus.idex_clr = 1'b1;
        bus.exmem_ld = 1'b0;
        bus.memwb_ld = 1'b0;
      end
      W_FREEZE: begin
        bus.pc_ld    = 1'b0;
        bus.ifid_ld  = 1'b0;
        bus.idex_ld  = 1'b0;
        bus.exmem_ld = 1'b0;
        bus.memwb_ld = 1'b0;
        bus.mem_busy = 1'b1;
      end
      W_FLUSH: begin
        bus.ifid_clr = 1'b1;
        bus.idex_clr = 1'b1;
      end
      W_BUBBLE: begin
        bus.pc_ld    = 1'b0;
        bus.ifid_ld  = 1'b0;
        bus.idex_clr = 1'b1;
      end
      default: ;
    endcase
  end

  // MEM_DONE deliberately ignores mem_req: that request is the access just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.mem_req && MEM_STALL_EN) begin
            if (ONE_WAIT) begin
              state <= MEM_DONE;
            end else begin
              state <= MEM_WAIT;
              cnt   <= LOAD_VAL;
            end
          end
        end
        MEM_WAIT: begin
          if (cnt == '0)
            state <= MEM_DONE;
          else
            cnt <= cnt - CNT_W'(1);
        end
        MEM_DONE: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((word == W_FREEZE || word == W_BUBBLE) && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (word == W_FLUSH && flush_q != 16'hFFFF)
        flush_q <= flush_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = 16'd0;
  assign bus.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_reg_ctrl.sv
// Directed bench for pipe_reg_ctrl: one instance with WAIT_CYCLES=3 and one with WAIT_CYCLES=0.
// Control word packing: {pc_ld, ifid_ld, ifid_clr, idex_ld, idex_clr, exmem_ld, memwb_ld, mem_busy}.
module tb_pipe_reg_ctrl;

  localparam logic [7:0] NORMAL = 8'b1101_0110;
  localparam logic [7:0] FREEZE = 8'b0000_0001;
  localparam logic [7:0] FLUSH  = 8'b1111_1110;
  localparam logic [7:0] BUBBLE = 8'b0001_1110;
  localparam logic [7:0] RESETW = 8'b0010_1000;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_reg_ctrl_if bus3 ();
  pipe_reg_ctrl_if bus0 ();

  pipe_reg_ctrl #(.WAIT_CYCLES(3), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus3.master)
  );

  pipe_reg_ctrl #(.WAIT_CYCLES(0), .CNT_W(4)) dut_nowait (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  wire [7:0] obs3 = {bus3.pc_ld, bus3.ifid_ld, bus3.ifid_clr, bus3.idex_ld,
                     bus3.idex_clr, bus3.exmem_ld, bus3.memwb_ld, bus3.mem_busy};
  wire [7:0] obs0 = {bus0.pc_ld, bus0.ifid_ld, bus0.ifid_clr, bus0.idex_ld,
                     bus0.idex_clr, bus0.exmem_ld, bus0.memwb_ld, bus0.mem_busy};

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic drive3(input logic m, input logic h, input logic b);
    @(negedge clk);
    bus3.mem_req      = m;
    bus3.hazard       = h;
    bus3.branch_taken = b;
    #1;
  endtask

  task automatic drive0(input logic m, input logic h, input logic b);
    @(negedge clk);
    bus0.mem_req      = m;
    bus0.hazard       = h;
    bus0.branch_taken = b;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus3.mem_req = 1'b1; bus3.hazard = 1'b1; bus3.branch_taken = 1'b1;
    bus0.mem_req = 1'b1; bus0.hazard = 1'b1; bus0.branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs3 !== RESETW) begin
        errors++;
        $display("[TB] FAIL reset_word cycle %0d: got %b expected %b", i, obs3, RESETW);
      end
      checks++;
      if (obs0 !== RESETW) begin
        errors++;
        $display("[TB] FAIL reset_word_nowait cycle %0d: got %b expected %b", i, obs0, RESETW);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus3.mem_req = 1'b0; bus3.hazard = 1'b0; bus3.branch_taken = 1'b0;
    bus0.mem_req = 1'b0; bus0.hazard = 1'b0; bus0.branch_taken = 1'b0;
    #1;
    checks++;
    if (obs3 !== NORMAL) begin
      errors++;
      $display("[TB] FAIL after_reset_word: got %b expected %b", obs3, NORMAL);
    end
    checks++;
    if (bus3.stall_cnt !== 16'd0 || bus3.flush_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL after_reset_counters: got stall=%0d flush=%0d expected 0/0",
               bus3.stall_cnt, bus3.flush_cnt);
    end
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_mem_wait();
    logic [7:0] exp [4] = '{FREEZE, FREEZE, FREEZE, NORMAL};
    for (int i = 0; i < 4; i++) begin
      drive3(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs3 !== exp[i]) begin
        errors++;
        $display("[TB] FAIL mem_wait cycle %0d: got %b expected %b", i, obs3, exp[i]);
      end
    end
    exp_stall += 3;
    drive3(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs3 !== NORMAL) begin
      errors++;
      $display("[TB] FAIL mem_wait_idle: got %b expected %b", obs3, NORMAL);
    end
    checks++;
    if (bus3.stall_cnt !== (PERF ? 16'(exp_stall) : 16'd0)) begin
      errors++;
      $display("[TB] FAIL mem_wait_stall_cnt: got %0d expected %0d",
               bus3.stall_cnt, PERF ? exp_stall : 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8] = '{FREEZE, FREEZE, FREEZE, NORMAL, FREEZE, FREEZE, FREEZE, NORMAL};
    for (int i = 0; i < 8; i++) begin
      drive3(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs3 !== exp[i]) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", i, obs3, exp[i]);
      end
    end
    exp_stall += 6;
    drive3(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_hazard_branch();
    drive3(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs3 !== BUBBLE) begin
      errors++;
      $display("[TB] FAIL hazard_bubble: got %b expected %b", obs3, BUBBLE);
    end
    exp_stall += 1;
    drive3(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs3 !== NORMAL) begin
      errors++;
      $display("[TB] FAIL hazard_release: got %b expected %b", obs3, NORMAL);
    end
    drive3(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs3 !== FLUSH) begin
      errors++;
      $display("[TB] FAIL branch_over_hazard: got %b expected %b", obs3, FLUSH);
    end
    exp_flush += 1;
    drive3(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs3 !== NORMAL) begin
      errors++;
      $display("[TB] FAIL branch_release: got %b expected %b", obs3, NORMAL);
    end
    checks++;
    if (bus3.flush_cnt !== (PERF ? 16'(exp_flush) : 16'd0) ||
        bus3.stall_cnt !== (PERF ? 16'(exp_stall) : 16'd0)) begin
      errors++;
      $display("[TB] FAIL hazard_branch_counters: got stall=%0d flush=%0d expected %0d/%0d",
               bus3.stall_cnt, bus3.flush_cnt, PERF ? exp_stall : 0, PERF ? exp_flush : 0);
    end
  endtask

  task automatic test_branch_during_freeze();
    logic [7:0] exp [5] = '{FREEZE, FREEZE, FREEZE, FLUSH, NORMAL};
    logic       br  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       mr  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive3(mr[i], 1'b0, br[i]);
      checks++;
      if (obs3 !== exp[i]) begin
        errors++;
        $display("[TB] FAIL branch_in_freeze cycle %0d: got %b expected %b", i, obs3, exp[i]);
      end
    end
    exp_stall += 3;
    exp_flush += 1;
    checks++;
    if (bus3.flush_cnt !== (PERF ? 16'(exp_flush) : 16'd0) ||
        bus3.stall_cnt !== (PERF ? 16'(exp_stall) : 16'd0)) begin
      errors++;
      $display("[TB] FAIL branch_in_freeze_counters: got stall=%0d flush=%0d expected %0d/%0d",
               bus3.stall_cnt, bus3.flush_cnt, PERF ? exp_stall : 0, PERF ? exp_flush : 0);
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 2; i++) begin
      drive3(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs3 !== FREEZE) begin
        errors++;
        $display("[TB] FAIL mid_wait_freeze cycle %0d: got %b expected %b", i, obs3, FREEZE);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs3 !== RESETW) begin
      errors++;
      $display("[TB] FAIL mid_wait_reset_word: got %b expected %b", obs3, RESETW);
    end
    @(negedge clk);
    rst = 1'b0;
    bus3.mem_req = 1'b0;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    checks++;
    if (obs3 !== NORMAL) begin
      errors++;
      $display("[TB] FAIL mid_wait_after_reset: got %b expected %b", obs3, NORMAL);
    end
    checks++;
    if (bus3.stall_cnt !== 16'd0 || bus3.flush_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL mid_wait_counters: got stall=%0d flush=%0d expected 0/0",
               bus3.stall_cnt, bus3.flush_cnt);
    end
  endtask

  task automatic test_zero_wait();
    logic [7:0] exp [8] = '{NORMAL, NORMAL, NORMAL, NORMAL, NORMAL, BUBBLE, FLUSH, FLUSH};
    logic       hz  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       br  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive0(1'b1, hz[i], br[i]);
      checks++;
      if (obs0 !== exp[i]) begin
        errors++;
        $display("[TB] FAIL zero_wait cycle %0d: got %b expected %b", i, obs0, exp[i]);
      end
    end
    drive0(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_mem_wait();
    test_back_to_back();
    test_hazard_branch();
    test_branch_during_freeze();
    test_reset_mid_wait();
    test_zero_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_ctrl.md
# pipe_reg_ctrl

Central sequencer for the load (`ld`) and clear (`clr`) controls of the PC and the four ARM pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It combines load-use hazard, taken-branch flush and a fixed-latency SRAM wait-state stall into one prioritised control word. It sits beside the hazard unit and memory stage and drives every pipeline register instance directly.

## Interface
- `WAIT_CYCLES`, 3: cycles the whole pipeline is frozen per memory access; 0 disables memory stalls.
- `CNT_W`, 4: width of the wait-state counter; must hold `WAIT_CYCLES`.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `mem_req` in 1: MEM stage holds a load or store this cycle.
- `hazard` in 1: load-use hazard detected in ID.
- `branch_taken` in 1: EX resolved a taken branch.
- `pc_ld` out 1: PC load enable.
- `ifid_ld`, `ifid_clr` out 1 each: IF/ID load and clear.
- `idex_ld`, `idex_clr` out 1 each: ID/EX load and clear.
- `exmem_ld` out 1: EX/MEM load enable.
- `memwb_ld` out 1: MEM/WB load enable.
- `mem_busy` out 1: high in every frozen memory-wait cycle.
- `stall_cnt` out 16, `flush_cnt` out 16: performance counters (see Configuration).

## Operation
- States: RUN, MEM_WAIT, MEM_DONE. Wait counter `cnt` (`CNT_W` bits).
- Control outputs are combinational from state and inputs; state, `cnt` and perf counters are registered.
- Freeze word: all `*_ld`=0, all `*_clr`=0, `mem_busy`=1.
- Normal word: all `*_ld`=1, all `*_clr`=0, `mem_busy`=0.
- Priority, highest first: reset > memory freeze > branch flush > hazard bubble.
- RUN, `mem_req`=1 and `WAIT_CYCLES`>0: freeze word; if `WAIT_CYCLES`=1 go MEM_DONE, else go MEM_WAIT with `cnt`=`WAIT_CYCLES`-2.
- MEM_WAIT: freeze word regardless of inputs; if `cnt`=0 go MEM_DONE, else `cnt`-1.
- MEM_DONE: `mem_req` is ignored (it belongs to the access just served); branch/hazard evaluated as in RUN; go RUN.
- Branch flush (`branch_taken`=1, not frozen): normal word plus `ifid_clr`=1, `idex_clr`=1; `hazard` ignored this cycle.
- Hazard bubble (`hazard`=1, no branch, not frozen): `pc_ld`=0, `ifid_ld`=0, `idex_clr`=1, `idex_ld`=1, `exmem_ld`=1, `memwb_ld`=1.
- `mem_req` with `WAIT_CYCLES`=0: never stalls; branch/hazard apply directly in RUN.
- A `clr` output is never asserted while the same register's `ld` is 0, except during reset.

## Timing
- Reset (`rst`=1 at an edge): state RUN, `cnt`=0, perf counters 0. While `rst` is high: all `*_ld`=0, `ifid_clr`=1, `idex_clr`=1, `mem_busy`=0. Reset mid-wait aborts the stall at the next edge.
- Memory access: exactly `WAIT_CYCLES` consecutive freeze cycles, starting in the cycle `mem_req` is first seen in RUN, then one MEM_DONE cycle in which the pipeline advances.
- Back-to-back: `mem_req` high again in the cycle after MEM_DONE (RUN) starts a new stall.
- Branch or hazard arriving during a freeze is held by the frozen registers and acted on in MEM_DONE.
- Zero added latency: branch flush and hazard bubble take effect in the cycle they are asserted.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `stall_cnt` increments on every cycle with `mem_busy`=1 or a hazard bubble. `flush_cnt` increments on every branch-flush cycle. Both are saturating at 16'hFFFF and cleared by `rst`.
- Not defined: counters are not built, and `stall_cnt` and `flush_cnt` are tied to 0.

## Test plan
- Reset: `rst`=1 for 2 cycles with all inputs high -> all `ld`=0, `ifid_clr`=`idex_clr`=1. After release with idle inputs -> normal word.
- `WAIT_CYCLES`=3, single `mem_req` held 4 cycles -> `mem_busy`=1 for exactly 3 cycles, then 1 cycle of normal word; `stall_cnt`=3 with PERF_EN.
- `hazard`=1 for 1 cycle -> `pc_ld`=`ifid_ld`=0, `idex_clr`=1 for that cycle only. `branch_taken`=1 with `hazard`=1 -> flush word only, `flush_cnt`=1.
- `branch_taken`=1 arriving in the 2nd frozen cycle and held -> freeze word continues, flush is applied in MEM_DONE.
- `rst` pulsed in the 2nd cycle of MEM_WAIT -> next cycle is RUN with the normal word, and `stall_cnt`=0.
- `WAIT_CYCLES`=0 with `mem_req`=1 continuously -> `mem_busy` never asserted and the normal word is output every cycle.
